// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared char constants and arbiter state encoding
package cpu_trace_pkg;

    localparam logic [7:0] CH_CARET = 8'h5E;
    localparam logic [7:0] CH_HASH  = 8'h23;
    localparam logic [7:0] CH_FILL  = 8'h00;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_GRANT = 2'd1;
    localparam arb_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first request at or after ptr
module rr_pick #(
    parameter int N_SRC = 2
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic [N_SRC-1:0] o_gnt,
    output logic [2:0]       o_gnt_idx,
    output logic             o_any
);

    localparam int IW = $clog2(N_SRC);

    logic [3:0] w_base;
    logic [3:0] w_idx;

    // Pointer is held modulo N_SRC so an out-of-range value still selects a real source.
    assign w_base = 4'(int'(i_ptr) % N_SRC);

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = w_base + 4'(k);
            if (w_idx >= 4'(N_SRC)) begin
                w_idx = w_idx - 4'(N_SRC);
            end
            if (!o_any && i_req[w_idx[IW-1:0]]) begin
                o_any                 = 1'b1;
                o_gnt[w_idx[IW-1:0]]  = 1'b1;
                o_gnt_idx             = 3'(w_idx);
            end
        end
    end

endmodule

// File: rtl/trace_stream_arbiter.sv
// rtl/trace_stream_arbiter.sv - record-granular arbiter feeding one non-stallable checker char input
module trace_stream_arbiter
    import cpu_trace_pkg::*;
#(
    parameter int         N_SRC       = 2,
    parameter int         MAX_REC_LEN = 64,
    parameter logic [7:0] FILL_CHAR   = CH_FILL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [8*N_SRC-1:0]   src_char,
    output logic [N_SRC-1:0]     src_ready,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    output logic [2:0]           grant_id,
    output logic                 rec_abort,
    output logic [7:0]           abort_cnt
);

    localparam int             IW       = $clog2(N_SRC);
    localparam int             RLW      = $clog2(MAX_REC_LEN + 1);
    localparam logic [RLW-1:0] LEN_MAX  = RLW'(MAX_REC_LEN);
    localparam logic [2:0]     LAST_SRC = 3'(N_SRC - 1);

    arb_state_t       r_state;
    logic [2:0]       r_rr_ptr;
    logic [RLW-1:0]   r_rec_len;
    logic [7:0]       r_out_char;
    logic             r_out_valid;
    logic [2:0]       r_grant_id;
    logic             r_rec_abort;
    logic [7:0]       r_abort_cnt;

    logic [7:0]       w_chars [N_SRC];
    logic [N_SRC-1:0] w_caret_req;
    logic [N_SRC-1:0] w_pick_gnt;
    logic [2:0]       w_pick_idx;
    logic             w_pick_any;

    logic [IW-1:0]    w_g;
    logic             w_g_valid;
    logic [7:0]       w_g_char;
    logic [2:0]       w_g_next;

    logic [N_SRC-1:0] w_ready;
    logic             w_fwd;
    logic [7:0]       w_fwd_char;
    logic             w_abort;
    arb_state_t       w_nxt_state;
    logic [2:0]       w_nxt_grant;
    logic [2:0]       w_nxt_ptr;
    logic [RLW-1:0]   w_nxt_len;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign w_chars[i]     = src_char[8*i +: 8];
        assign w_caret_req[i] = src_valid[i] && (w_chars[i] == CH_CARET);
    end

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_rr_pick (
        .i_req     (w_caret_req),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_pick_gnt),
        .o_gnt_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    assign w_g       = r_grant_id[IW-1:0];
    assign w_g_valid = src_valid[w_g];
    assign w_g_char  = w_chars[w_g];
    assign w_g_next  = (r_grant_id == LAST_SRC) ? 3'd0 : r_grant_id + 3'd1;

    always_comb begin
        w_ready     = '0;
        w_fwd       = 1'b0;
        w_fwd_char  = FILL_CHAR;
        w_abort     = 1'b0;
        w_nxt_state = r_state;
        w_nxt_grant = r_grant_id;
        w_nxt_ptr   = r_rr_ptr;
        w_nxt_len   = r_rec_len;
        case (r_state)
            ST_IDLE: begin
                // Non-record heads are swallowed so a stray byte cannot block a source forever.
                for (int i = 0; i < N_SRC; i++) begin
                    w_ready[i] = src_valid[i] && (w_chars[i] != CH_CARET);
                end
                w_ready = w_ready | w_pick_gnt;
                if (w_pick_any) begin
                    w_fwd       = 1'b1;
                    w_fwd_char  = CH_CARET;
                    w_nxt_grant = w_pick_idx;
                    w_nxt_len   = RLW'(1);
                    w_nxt_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_ready[w_g] = 1'b1;
                if (!w_g_valid) begin
                    w_abort     = 1'b1;
                    w_nxt_state = ST_DRAIN;
                end else if ((r_rec_len == LEN_MAX) && (w_g_char != CH_HASH)) begin
                    // Overlong char is consumed but never reaches the checker.
                    w_abort     = 1'b1;
                    w_nxt_state = ST_DRAIN;
                end else begin
                    w_fwd      = 1'b1;
                    w_fwd_char = w_g_char;
                    w_nxt_len  = r_rec_len + RLW'(1);
                    if (w_g_char == CH_HASH) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_ptr   = w_g_next;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_g_valid && (w_g_char == CH_CARET)) begin
                    // Leave the new record's '^' in place so it competes in IDLE.
                    w_nxt_state = ST_IDLE;
                    w_nxt_ptr   = w_g_next;
                end else begin
                    w_ready[w_g] = 1'b1;
                    if (w_g_valid && (w_g_char == CH_HASH)) begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_ptr   = w_g_next;
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 3'd0;
            r_rec_len   <= '0;
            r_out_char  <= FILL_CHAR;
            r_out_valid <= 1'b0;
            r_grant_id  <= 3'd0;
            r_rec_abort <= 1'b0;
            r_abort_cnt <= 8'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_rr_ptr    <= w_nxt_ptr;
            r_rec_len   <= w_nxt_len;
            r_grant_id  <= w_nxt_grant;
            r_out_char  <= w_fwd ? w_fwd_char : FILL_CHAR;
            r_out_valid <= w_fwd;
            r_rec_abort <= w_abort;
            if (w_abort && (r_abort_cnt != 8'hFF)) begin
                r_abort_cnt <= r_abort_cnt + 8'd1;
            end
        end
    end

    assign src_ready = w_ready;
    assign out_char  = r_out_char;
    assign out_valid = r_out_valid;
    assign grant_id  = r_grant_id;
    assign rec_abort = r_rec_abort;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// tb/tb_trace_stream_arbiter.sv - directed self-checking bench for trace_stream_arbiter
module tb_trace_stream_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_char, b_char;
    logic [7:0]  a_out_char, b_out_char, a_cnt, b_cnt;
    logic        a_out_valid, b_out_valid, a_abort, b_abort;
    logic [2:0]  a_gid, b_gid;
    logic [1:0]  rdy_s;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    trace_stream_arbiter #(.N_SRC(2), .MAX_REC_LEN(64), .FILL_CHAR(8'h00)) dut_a (
        .clk(clk), .reset(reset), .src_valid(a_valid), .src_char(a_char), .src_ready(a_ready),
        .out_char(a_out_char), .out_valid(a_out_valid), .grant_id(a_gid),
        .rec_abort(a_abort), .abort_cnt(a_cnt)
    );

    trace_stream_arbiter #(.N_SRC(2), .MAX_REC_LEN(16), .FILL_CHAR(8'h00)) dut_b (
        .clk(clk), .reset(reset), .src_valid(b_valid), .src_char(b_char), .src_ready(b_ready),
        .out_char(b_out_char), .out_valid(b_out_valid), .grant_id(b_gid),
        .rec_abort(b_abort), .abort_cnt(b_cnt)
    );

    typedef struct packed {
        logic       v0;
        logic [7:0] c0;
        logic       v1;
        logic [7:0] c1;
        logic [1:0] rdy;
        logic       ov;
        logic [7:0] oc;
        logic [2:0] gid;
        logic       ab;
        logic [7:0] cnt;
    } row_t;

    function automatic row_t mk(input logic v0, input logic [7:0] c0, input logic v1,
                                input logic [7:0] c1, input logic [1:0] rdy, input logic ov,
                                input logic [7:0] oc, input logic [2:0] gid, input logic ab,
                                input logic [7:0] cnt);
        return {v0, c0, v1, c1, rdy, ov, oc, gid, ab, cnt};
    endfunction

    task automatic drive_a(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
        a_valid = {v1, v0};
        a_char  = {c1, c0};
        @(negedge clk);
        rdy_s = a_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v0, input logic [7:0] c0);
        b_valid = {1'b0, v0};
        b_char  = {8'h00, c0};
        @(negedge clk);
        rdy_s = b_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; a_valid = 2'b00; a_char = 16'h0; b_valid = 2'b00; b_char = 16'h0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({a_out_valid, a_out_char, a_gid, a_abort, a_cnt, a_ready} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b c=%h g=%0d ab=%b cnt=%0d rdy=%b want all zero",
                     a_out_valid, a_out_char, a_gid, a_abort, a_cnt, a_ready);
        end
        n_checks++;
        if ({b_out_valid, b_out_char, b_gid, b_abort, b_cnt, b_ready} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b c=%h g=%0d ab=%b cnt=%0d rdy=%b want all zero",
                     b_out_valid, b_out_char, b_gid, b_abort, b_cnt, b_ready);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_record();
        string s = "^12@00003000: $3 <= 0000000a#";
        for (int k = 0; k < s.len(); k++) begin
            drive_a(1'b1, s[k], 1'b0, 8'h00);
            n_checks++;
            if (rdy_s !== 2'b01) begin
                n_fail++;
                $display("FAIL t1_ready char %0d: got %b want 01", k, rdy_s);
            end
            n_checks++;
            if ({a_out_valid, a_out_char, a_gid, a_abort} !== {1'b1, s[k], 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL t1_out char %0d: got v=%b c=%h g=%0d ab=%b want v=1 c=%h g=0 ab=0",
                         k, a_out_valid, a_out_char, a_gid, a_abort, s[k]);
            end
        end
        drive_a(1'b0, 8'h00, 1'b0, 8'h00);
        n_checks++;
        if ({a_out_valid, a_out_char, a_abort} !== 10'h0) begin
            n_fail++;
            $display("FAIL t1_idle: got v=%b c=%h ab=%b want v=0 c=00 ab=0", a_out_valid, a_out_char, a_abort);
        end
    endtask

    task automatic test_contention();
        row_t rows [9];
        reset = 1'b0; a_valid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b1;
        rows = '{
            mk(1'b1, "^", 1'b1, "^", 2'b01, 1'b1, "^",   3'd0, 1'b0, 8'd0),
            mk(1'b1, "A", 1'b1, "^", 2'b01, 1'b1, "A",   3'd0, 1'b0, 8'd0),
            mk(1'b1, "#", 1'b1, "^", 2'b01, 1'b1, "#",   3'd0, 1'b0, 8'd0),
            mk(1'b0, " ", 1'b1, "^", 2'b10, 1'b1, "^",   3'd1, 1'b0, 8'd0),
            mk(1'b0, " ", 1'b1, "B", 2'b10, 1'b1, "B",   3'd1, 1'b0, 8'd0),
            mk(1'b0, " ", 1'b1, "#", 2'b10, 1'b1, "#",   3'd1, 1'b0, 8'd0),
            mk(1'b1, "^", 1'b1, "^", 2'b01, 1'b1, "^",   3'd0, 1'b0, 8'd0),
            mk(1'b1, "#", 1'b1, "^", 2'b01, 1'b1, "#",   3'd0, 1'b0, 8'd0),
            mk(1'b0, " ", 1'b0, " ", 2'b00, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0)
        };
        for (int k = 0; k < 9; k++) begin
            drive_a(rows[k].v0, rows[k].c0, rows[k].v1, rows[k].c1);
            n_checks++;
            if (rdy_s !== rows[k].rdy) begin
                n_fail++;
                $display("FAIL t2_ready row %0d: got %b want %b", k, rdy_s, rows[k].rdy);
            end
            n_checks++;
            if ({a_out_valid, a_out_char, a_gid, a_abort, a_cnt} !==
                {rows[k].ov, rows[k].oc, rows[k].gid, rows[k].ab, rows[k].cnt}) begin
                n_fail++;
                $display("FAIL t2_out row %0d: got v=%b c=%h g=%0d ab=%b cnt=%0d want v=%b c=%h g=%0d ab=%b cnt=%0d",
                         k, a_out_valid, a_out_char, a_gid, a_abort, a_cnt,
                         rows[k].ov, rows[k].oc, rows[k].gid, rows[k].ab, rows[k].cnt);
            end
        end
    endtask

    task automatic test_underflow();
        row_t rows [13];
        rows = '{
            mk(1'b0, " ", 1'b1, "^", 2'b10, 1'b1, "^",   3'd1, 1'b0, 8'd0),
            mk(1'b0, " ", 1'b1, "Q", 2'b10, 1'b1, "Q",   3'd1, 1'b0, 8'd0),
            mk(1'b0, " ", 1'b0, " ", 2'b10, 1'b0, 8'h00, 3'd1, 1'b1, 8'd1),
            mk(1'b0, " ", 1'b1, "R", 2'b10, 1'b0, 8'h00, 3'd1, 1'b0, 8'd1),
            mk(1'b0, " ", 1'b1, "S", 2'b10, 1'b0, 8'h00, 3'd1, 1'b0, 8'd1),
            mk(1'b0, " ", 1'b1, "#", 2'b10, 1'b0, 8'h00, 3'd1, 1'b0, 8'd1),
            mk(1'b1, "^", 1'b1, "^", 2'b01, 1'b1, "^",   3'd0, 1'b0, 8'd1),
            mk(1'b1, "#", 1'b1, "^", 2'b01, 1'b1, "#",   3'd0, 1'b0, 8'd1),
            mk(1'b0, " ", 1'b1, "^", 2'b10, 1'b1, "^",   3'd1, 1'b0, 8'd1),
            mk(1'b0, " ", 1'b0, " ", 2'b10, 1'b0, 8'h00, 3'd1, 1'b1, 8'd2),
            mk(1'b0, " ", 1'b1, "^", 2'b00, 1'b0, 8'h00, 3'd1, 1'b0, 8'd2),
            mk(1'b0, " ", 1'b1, "^", 2'b10, 1'b1, "^",   3'd1, 1'b0, 8'd2),
            mk(1'b0, " ", 1'b1, "#", 2'b10, 1'b1, "#",   3'd1, 1'b0, 8'd2)
        };
        for (int k = 0; k < 13; k++) begin
            drive_a(rows[k].v0, rows[k].c0, rows[k].v1, rows[k].c1);
            n_checks++;
            if (rdy_s !== rows[k].rdy) begin
                n_fail++;
                $display("FAIL t3_ready row %0d: got %b want %b", k, rdy_s, rows[k].rdy);
            end
            n_checks++;
            if ({a_out_valid, a_out_char, a_gid, a_abort, a_cnt} !==
                {rows[k].ov, rows[k].oc, rows[k].gid, rows[k].ab, rows[k].cnt}) begin
                n_fail++;
                $display("FAIL t3_out row %0d: got v=%b c=%h g=%0d ab=%b cnt=%0d want v=%b c=%h g=%0d ab=%b cnt=%0d",
                         k, a_out_valid, a_out_char, a_gid, a_abort, a_cnt,
                         rows[k].ov, rows[k].oc, rows[k].gid, rows[k].ab, rows[k].cnt);
            end
        end
    endtask

    task automatic test_garbage();
        row_t rows [6];
        rows = '{
            mk(1'b1, "x", 1'b1, "k", 2'b11, 1'b0, 8'h00, 3'd1, 1'b0, 8'd2),
            mk(1'b1, "y", 1'b0, " ", 2'b01, 1'b0, 8'h00, 3'd1, 1'b0, 8'd2),
            mk(1'b1, "z", 1'b0, " ", 2'b01, 1'b0, 8'h00, 3'd1, 1'b0, 8'd2),
            mk(1'b1, "^", 1'b0, " ", 2'b01, 1'b1, "^",   3'd0, 1'b0, 8'd2),
            mk(1'b1, "1", 1'b0, " ", 2'b01, 1'b1, "1",   3'd0, 1'b0, 8'd2),
            mk(1'b1, "#", 1'b0, " ", 2'b01, 1'b1, "#",   3'd0, 1'b0, 8'd2)
        };
        for (int k = 0; k < 6; k++) begin
            drive_a(rows[k].v0, rows[k].c0, rows[k].v1, rows[k].c1);
            n_checks++;
            if (rdy_s !== rows[k].rdy) begin
                n_fail++;
                $display("FAIL t5_ready row %0d: got %b want %b", k, rdy_s, rows[k].rdy);
            end
            n_checks++;
            if ({a_out_valid, a_out_char, a_gid, a_abort, a_cnt} !==
                {rows[k].ov, rows[k].oc, rows[k].gid, rows[k].ab, rows[k].cnt}) begin
                n_fail++;
                $display("FAIL t5_out row %0d: got v=%b c=%h g=%0d ab=%b cnt=%0d want v=%b c=%h g=%0d ab=%b cnt=%0d",
                         k, a_out_valid, a_out_char, a_gid, a_abort, a_cnt,
                         rows[k].ov, rows[k].oc, rows[k].gid, rows[k].ab, rows[k].cnt);
            end
        end
    endtask

    task automatic test_runaway();
        logic [7:0] ch, ec, ecnt;
        logic       ev, eab;
        int         n_fwd = 0;
        for (int k = 0; k < 22; k++) begin
            ch = (k == 0) ? 8'h5E : ((k == 21) ? 8'h23 : 8'h20);
            drive_b(1'b1, ch);
            ev   = (k <= 15);
            ec   = ev ? ch : 8'h00;
            eab  = (k == 16);
            ecnt = (k >= 16) ? 8'd1 : 8'd0;
            if (b_out_valid === 1'b1) n_fwd++;
            n_checks++;
            if (rdy_s !== 2'b01) begin
                n_fail++;
                $display("FAIL t4_ready char %0d: got %b want 01", k, rdy_s);
            end
            n_checks++;
            if ({b_out_valid, b_out_char, b_gid, b_abort, b_cnt} !== {ev, ec, 3'd0, eab, ecnt}) begin
                n_fail++;
                $display("FAIL t4_out char %0d: got v=%b c=%h g=%0d ab=%b cnt=%0d want v=%b c=%h g=0 ab=%b cnt=%0d",
                         k, b_out_valid, b_out_char, b_gid, b_abort, b_cnt, ev, ec, eab, ecnt);
            end
        end
        n_checks++;
        if (n_fwd != 16) begin
            n_fail++;
            $display("FAIL t4_fwd_count: got %0d want 16", n_fwd);
        end
        for (int k = 0; k < 16; k++) begin
            ch = (k == 0) ? 8'h5E : ((k == 15) ? 8'h23 : 8'h61);
            drive_b(1'b1, ch);
            n_checks++;
            if ({b_out_valid, b_out_char, b_abort, b_cnt} !== {1'b1, ch, 1'b0, 8'd1}) begin
                n_fail++;
                $display("FAIL t4_maxlen char %0d: got v=%b c=%h ab=%b cnt=%0d want v=1 c=%h ab=0 cnt=1",
                         k, b_out_valid, b_out_char, b_abort, b_cnt, ch);
            end
        end
        drive_b(1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_grant();
        drive_a(1'b1, "^", 1'b1, "^");
        n_checks++;
        if ({rdy_s, a_out_valid, a_out_char, a_gid} !== {2'b10, 1'b1, 8'h5E, 3'd1}) begin
            n_fail++;
            $display("FAIL t6_pre: got rdy=%b v=%b c=%h g=%0d want rdy=10 v=1 c=5e g=1",
                     rdy_s, a_out_valid, a_out_char, a_gid);
        end
        drive_a(1'b0, 8'h00, 1'b1, "a");
        a_char = {8'h62, 8'h00};
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({a_out_valid, a_out_char, a_gid, a_abort, a_cnt} !== 21'h0) begin
            n_fail++;
            $display("FAIL t6_async_reset: got v=%b c=%h g=%0d ab=%b cnt=%0d want all zero",
                     a_out_valid, a_out_char, a_gid, a_abort, a_cnt);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive_a(1'b1, "^", 1'b1, "^");
        n_checks++;
        if ({rdy_s, a_out_valid, a_out_char, a_gid} !== {2'b01, 1'b1, 8'h5E, 3'd0}) begin
            n_fail++;
            $display("FAIL t6_restart: got rdy=%b v=%b c=%h g=%0d want rdy=01 v=1 c=5e g=0",
                     rdy_s, a_out_valid, a_out_char, a_gid);
        end
        drive_a(1'b1, "#", 1'b1, "^");
        drive_a(1'b0, 8'h00, 1'b1, "^");
        n_checks++;
        if ({rdy_s, a_out_valid, a_out_char, a_gid} !== {2'b10, 1'b1, 8'h5E, 3'd1}) begin
            n_fail++;
            $display("FAIL t6_second: got rdy=%b v=%b c=%h g=%0d want rdy=10 v=1 c=5e g=1",
                     rdy_s, a_out_valid, a_out_char, a_gid);
        end
    endtask

    initial begin
        test_reset();
        test_single_record();
        test_contention();
        test_underflow();
        test_garbage();
        test_runaway();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
